shift_scheduler: RTL and testbench
==================================

SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

Interface
REQ-001 Parameter PERIOD, default 8: auto-sweep tick interval in clocks; SHALL be at least 2.
REQ-002 Parameter GAP, default 2: holdoff length after each pulse; SHALL be at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 btn_left  input  1  synchronized level request to move the lit position left.
REQ-006 btn_right  input  1  synchronized level request to move the lit position right.
REQ-007 auto_en  input  1  high enables automatic bouncing sweep.
REQ-008 shift_left  output  1  one-cycle pulse to the shifter's shift_left input.
REQ-009 shift_right  output  1  one-cycle pulse to the shifter's shift_right input.
REQ-010 pos  output  2  mirrored shifter position: 0 = leftmost (4'b1000), 3 = rightmost (4'b0001).
REQ-011 auto_dir  output  1  current sweep direction: 1 = rightward, 0 = leftward.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Button edge detect: a button sampled high at an edge, after being sampled low at the previous edge, SHALL set its pending flag (pend_l or pend_r) at that edge; a held button SHALL NOT re-trigger.
REQ-014 Timer: while auto_en=1, a counter SHALL count 0..PERIOD-1 and wrap; at wrap it SHALL set pend_a.
REQ-015 auto_en=0 SHALL clear the timer and pend_a in the same cycle.
REQ-016 A pending flag that is already set SHALL absorb further requests of the same kind (no queueing beyond one).
REQ-017 The FSM SHALL have three states: IDLE, PULSE and HOLDOFF.
REQ-018 IDLE -> PULSE when any pending flag is set; grant priority SHALL be pend_l > pend_r > pend_a, and the granted flag SHALL be cleared on entry to PULSE.
REQ-019 PULSE SHALL last exactly 1 cycle, then go to HOLDOFF.
REQ-020 HOLDOFF SHALL last GAP-1 cycles, then go to IDLE.
REQ-021 Outputs SHALL be registered, and shift_left/shift_right SHALL be high only in PULSE.
REQ-022 At most one of shift_left/shift_right SHALL be high in any cycle.
REQ-023 Back-to-back requests SHALL produce pulse starts spaced exactly GAP+1 cycles apart.
REQ-024 Latency: a pulse SHALL start 1 cycle after the edge at which its pending flag is set, provided the FSM is in IDLE.
REQ-025 Auto grant with auto_dir=1: if pos<3, issue right; if pos==3, issue left and clear auto_dir.
REQ-026 Auto grant with auto_dir=0: if pos>0, issue left; if pos==0, issue right and set auto_dir.
REQ-027 pos SHALL update when a pulse is issued: right increments it saturating at 3, left decrements it saturating at 0. This matches the shifter's saturation.
REQ-028 Button pulses SHALL update pos but SHALL NOT change auto_dir.
REQ-029 A button pulse that is ineffective at a wall SHALL still be issued, with pos unchanged.
REQ-030 Simultaneous rising edges on btn_left and btn_right SHALL set both flags; left SHALL be served first and right after the holdoff.
REQ-031 Requests arriving during PULSE or HOLDOFF SHALL be latched and served on return to IDLE.

Reset
REQ-032 reset_n=0 SHALL immediately force: state=IDLE, shift_left=0, shift_right=0, pos=0, auto_dir=1, busy=0, all pending flags=0, timer=0, and button history=0.
REQ-033 A reset asserted mid-pulse SHALL drop the pulse asynchronously, and no request pending at that time SHALL survive reset.
REQ-034 On release of reset_n, a button already held high SHALL count as a rising edge at the first sampling edge.

Verification
REQ-035 Reset, then a btn_right rise with the button held 10 cycles -> exactly one shift_right pulse, 1 cycle wide; pos=1; busy high for GAP cycles.
REQ-036 btn_left and btn_right rise in the same cycle from pos=1 -> shift_left pulse, then shift_right pulse GAP+1 cycles later; pos ends at 1.
REQ-037 auto_en=1 with PERIOD=8 from reset -> right pulses take pos 1,2,3; then left pulses take pos 2,1,0 with auto_dir=0; then right with auto_dir=1; pulses spaced 8 cycles apart.
REQ-038 btn_left rises in the same cycle as an auto tick -> left pulse served first; auto pulse follows GAP+1 cycles later with correct direction for the new pos.
REQ-039 btn_left at pos=0 -> pulse issued, pos stays 0; auto_en dropped mid-count -> no further auto pulses, timer restarts from 0 on re-enable.
REQ-040 reset_n pulled low during PULSE -> shift_* go low without waiting for a clock edge; pos=0, auto_dir=1; no pulse after release unless a new edge occurs.

Source files
------------

// File: rtl/shift_scheduler.sv
// shift_scheduler
//   Turns button presses and a periodic auto-sweep tick into single-cycle
//   shift pulses for a 4-position one-hot shifter, spacing pulses by a
//   holdoff and mirroring the shifter's position and sweep direction.
//
// Parameters
//   PERIOD      auto-sweep tick interval in clocks (>= 2)
//   GAP         holdoff length after each pulse (>= 2); pulses start GAP+1 apart
//
// Ports
//   clk         clock, all state on rising edge
//   reset_n     asynchronous active-low reset
//   btn_left    synchronized level request: move lit position left
//   btn_right   synchronized level request: move lit position right
//   auto_en     enables the automatic bouncing sweep
//   shift_left  one-cycle pulse to the shifter's shift_left input
//   shift_right one-cycle pulse to the shifter's shift_right input
//   pos         mirrored position, 0 = leftmost, 3 = rightmost
//   auto_dir    sweep direction, 1 = rightward, 0 = leftward
//   busy        high whenever the scheduler is not idle
module shift_scheduler #(
    parameter int PERIOD = 8,
    parameter int GAP    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       auto_en,
    output logic       shift_left,
    output logic       shift_right,
    output logic [1:0] pos,
    output logic       auto_dir,
    output logic       busy
);

    localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int HW = (GAP > 2) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
    logic [TW-1:0] timer;
    logic          btn_l_q, btn_r_q;
    logic          pend_l, pend_r, pend_a;
    logic          rise_l, rise_r, tick, pend_a_eff;
    logic          grant_l, grant_r, grant_a;
    logic          go_left, go_right;
    logic [1:0]    pos_nxt;
    logic          dir_nxt;

    assign rise_l = btn_left & ~btn_l_q;
    assign rise_r = btn_right & ~btn_r_q;
    assign tick   = auto_en && (timer == TW'(PERIOD - 1));
    // A tick left over from before auto_en dropped must not be granted.
    assign pend_a_eff = pend_a & auto_en;

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        grant_l      = 1'b0;
        grant_r      = 1'b0;
        grant_a      = 1'b0;
        case (state)
            IDLE: begin
                if (pend_l) begin
                    grant_l   = 1'b1;
                    state_nxt = PULSE;
                end else if (pend_r) begin
                    grant_r   = 1'b1;
                    state_nxt = PULSE;
                end else if (pend_a_eff) begin
                    grant_a   = 1'b1;
                    state_nxt = PULSE;
                end
            end
            PULSE: begin
                state_nxt    = HOLDOFF;
                hold_cnt_nxt = '0;
            end
            HOLDOFF: begin
                if (hold_cnt == HW'(GAP - 2)) begin
                    state_nxt = IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Auto grants bounce off the walls; buttons always go where asked,
    // even when that is into a wall.
    always_comb begin
        go_left  = grant_l | (grant_a & (auto_dir ? (pos == 2'd3) : (pos != 2'd0)));
        go_right = grant_r | (grant_a & (auto_dir ? (pos != 2'd3) : (pos == 2'd0)));

        pos_nxt = pos;
        if (go_right && pos != 2'd3) pos_nxt = pos + 2'd1;
        if (go_left && pos != 2'd0)  pos_nxt = pos - 2'd1;

        dir_nxt = auto_dir;
        if (grant_a && auto_dir && pos == 2'd3)  dir_nxt = 1'b0;
        if (grant_a && !auto_dir && pos == 2'd0) dir_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            timer       <= '0;
            btn_l_q     <= 1'b0;
            btn_r_q     <= 1'b0;
            pend_l      <= 1'b0;
            pend_r      <= 1'b0;
            pend_a      <= 1'b0;
            shift_left  <= 1'b0;
            shift_right <= 1'b0;
            pos         <= 2'd0;
            auto_dir    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            btn_l_q  <= btn_left;
            btn_r_q  <= btn_right;
            // A fresh edge wins over the clear on grant, so it is not lost.
            pend_l   <= rise_l | (pend_l & ~grant_l);
            pend_r   <= rise_r | (pend_r & ~grant_r);
            if (!auto_en) begin
                timer  <= '0;
                pend_a <= 1'b0;
            end else begin
                timer  <= tick ? '0 : timer + 1'b1;
                pend_a <= tick | (pend_a & ~grant_a);
            end
            shift_left  <= go_left;
            shift_right <= go_right;
            pos         <= pos_nxt;
            auto_dir    <= dir_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_shift_scheduler.sv
module tb_shift_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_left, btn_right, auto_en;
    logic       shift_left, shift_right;
    logic [1:0] pos;
    logic       auto_dir, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    shift_scheduler #(.PERIOD(8), .GAP(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .auto_en    (auto_en),
        .shift_left (shift_left),
        .shift_right(shift_right),
        .pos        (pos),
        .auto_dir   (auto_dir),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One row per clock: inputs applied before the edge, outputs expected after it.
    typedef struct packed {
        logic       bl;
        logic       br;
        logic       sl;
        logic       sr;
        logic [1:0] pos;
        logic       busy;
        logic       dir;
    } vec_t;

    vec_t tbl [40];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_pulse(input int max_cyc, output logic found);
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (shift_left || shift_right) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [5:0] outs();
        return {shift_left, shift_right, pos, busy, auto_dir};
    endfunction

    logic       f;
    int         last, c0;
    logic [4:0] exp_auto [7];

    initial begin
        // bl br | sl sr | pos | busy dir
        tbl[0]  = 8'b01_00_00_01;  // right press, flag set
        tbl[1]  = 8'b01_01_01_11;  // right pulse, pos 1
        tbl[2]  = 8'b01_00_01_11;  // holdoff
        for (int i = 3; i <= 9; i++) tbl[i] = 8'b01_00_01_01;  // held, no retrigger
        tbl[10] = 8'b00_00_01_01;
        tbl[11] = 8'b11_00_01_01;  // both rise together
        tbl[12] = 8'b11_10_00_11;  // left first
        tbl[13] = 8'b11_00_00_11;
        tbl[14] = 8'b00_00_00_01;
        tbl[15] = 8'b00_01_01_11;  // right GAP+1 later
        tbl[16] = 8'b00_00_01_11;
        tbl[17] = 8'b00_00_01_01;
        tbl[18] = 8'b10_00_01_01;
        tbl[19] = 8'b10_10_00_11;  // left to 0
        tbl[20] = 8'b00_00_00_11;
        tbl[21] = 8'b00_00_00_01;
        tbl[22] = 8'b10_00_00_01;
        tbl[23] = 8'b10_10_00_11;  // left at wall: pulse, pos stays 0
        tbl[24] = 8'b00_00_00_11;
        tbl[25] = 8'b00_00_00_01;
        tbl[26] = 8'b01_00_00_01;
        tbl[27] = 8'b00_01_01_11;
        tbl[28] = 8'b01_00_01_11;  // press during pulse is latched
        tbl[29] = 8'b01_00_01_01;
        tbl[30] = 8'b00_01_10_11;  // served on return to idle
        tbl[31] = 8'b00_00_10_11;
        tbl[32] = 8'b00_00_10_01;
        tbl[33] = 8'b01_00_10_01;
        tbl[34] = 8'b00_01_11_11;  // pos 3
        tbl[35] = 8'b00_00_11_11;
        tbl[36] = 8'b01_00_11_01;
        tbl[37] = 8'b00_01_11_11;  // right at wall: pulse, pos stays 3
        tbl[38] = 8'b00_00_11_11;
        tbl[39] = 8'b00_00_11_01;

        // sl sr pos dir for the auto sweep from reset
        exp_auto[0] = 5'b0_1_01_1;
        exp_auto[1] = 5'b0_1_10_1;
        exp_auto[2] = 5'b0_1_11_1;
        exp_auto[3] = 5'b1_0_10_0;
        exp_auto[4] = 5'b1_0_01_0;
        exp_auto[5] = 5'b1_0_00_0;
        exp_auto[6] = 5'b0_1_01_1;

        reset_n   = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        auto_en   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", int'(outs()), int'(6'b00_00_0_1));
        reset_n = 1'b1;

        // Button sequences, one row per clock.
        for (int i = 0; i < 40; i++) begin
            btn_left  = tbl[i].bl;
            btn_right = tbl[i].br;
            @(negedge clk);
            checks++;
            if (outs() !== tbl[i][5:0]) begin
                errors++;
                $display("FAIL row_%0d: got {sl,sr,pos,busy,dir}=%b expected %b",
                         i, outs(), tbl[i][5:0]);
            end
        end

        // Auto sweep from reset.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        auto_en = 1'b1;
        c0   = cyc;
        last = c0;
        for (int k = 0; k < 7; k++) begin
            wait_pulse(20, f);
            chk($sformatf("auto_%0d_found", k), int'(f), 1);
            chk($sformatf("auto_%0d_out", k),
                int'({shift_left, shift_right, pos, auto_dir}), int'(exp_auto[k]));
            chk($sformatf("auto_%0d_spacing", k), cyc - last, (k == 0) ? 9 : 8);
            last = cyc;
        end

        // Left press lands on the same edge as the next auto tick.
        repeat (6) @(negedge clk);
        btn_left = 1'b1;
        wait_pulse(10, f);
        chk("tie_left_found", int'(f), 1);
        chk("tie_left_out", int'({shift_left, shift_right, pos, auto_dir}), int'(5'b1_0_00_1));
        chk("tie_left_time", cyc - last, 8);
        btn_left = 1'b0;
        wait_pulse(10, f);
        chk("tie_auto_found", int'(f), 1);
        chk("tie_auto_out", int'({shift_left, shift_right, pos, auto_dir}), int'(5'b0_1_01_1));
        chk("tie_auto_time", cyc - last, 11);

        // Disable mid-count: quiet; re-enable restarts the count from 0.
        auto_en = 1'b0;
        wait_pulse(20, f);
        chk("auto_off_quiet", int'(f), 0);
        auto_en = 1'b1;
        c0 = cyc;
        wait_pulse(20, f);
        chk("reenable_found", int'(f), 1);
        chk("reenable_out", int'({shift_left, shift_right, pos, auto_dir}), int'(5'b0_1_10_1));
        chk("reenable_time", cyc - c0, 9);

        // Reset pulled during the pulse drops it with no clock edge.
        reset_n = 1'b0;
        #1;
        chk("async_reset_out", int'(outs()), int'(6'b00_00_0_1));
        auto_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        wait_pulse(15, f);
        chk("post_reset_quiet", int'(f), 0);
        chk("post_reset_busy", int'(busy), 0);

        // Button held through reset release counts as a rising edge.
        reset_n  = 1'b0;
        btn_left = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        c0 = cyc;
        wait_pulse(10, f);
        chk("held_release_found", int'(f), 1);
        chk("held_release_out", int'({shift_left, shift_right, pos, auto_dir}), int'(5'b1_0_00_1));
        chk("held_release_time", cyc - c0, 2);
        wait_pulse(10, f);
        chk("held_no_retrigger", int'(f), 0);
        btn_left = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
